// File: rtl/jump_fsm_counter_pkg.sv
// Shared game-state encoding and keyboard keycodes for the jump controller.
package jump_pkg;

    typedef enum logic [2:0] {
        START = 3'b000,
        PLAY  = 3'b001,
        PAUSE = 3'b010
    } game_state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_P     = 8'h13;
    localparam logic [7:0] KEY_ESC   = 8'h29;

endpackage

// File: rtl/jump_fsm_counter_timer.sv
// Single counter stage: clear has priority over enable, and wrap flags the
// enabled frame on which the count rolls from all-ones back to zero.
module jump_timer #(
    parameter int WIDTH = 7
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;

    assign out  = r_count;
    assign wrap = en && (r_count == {WIDTH{1'b1}});

    // Count register with async reset, sync clear and enable.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/jump_fsm_counter.sv
// Game-flow FSM (start / play / pause) driven by keyboard press events, plus a
// two-stage cascaded frame counter used as gravity acceleration.
//
//   state | meaning
//   START | title screen, waiting for ENTER
//   PLAY  | game running, counters may advance
//   PAUSE | game frozen, counters hold
module jump_fsm_counter #(
    parameter int FAST_W = 7,
    parameter int SLOW_W = 2
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    input  logic              jump_en,
    input  logic              jump_clr,
    output logic [2:0]        outstate,
    output logic              loadplat,
    output logic [FAST_W-1:0] jump_count,
    output logic [SLOW_W-1:0] accel
);

    import jump_pkg::*;

    // Held as a plain vector so the unused encodings stay reachable and recover.
    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_loadplat;
    logic       w_loadplat_next;
    logic [7:0] r_key_prev;

    logic w_press_enter;
    logic w_press_p;
    logic w_press_esc;
    logic w_cnt_en;
    logic w_fast_wrap;
    logic w_slow_en;
    logic w_slow_wrap_unused;

    assign w_press_enter = (keycode == KEY_ENTER) && (r_key_prev != KEY_ENTER);
    assign w_press_p     = (keycode == KEY_P)     && (r_key_prev != KEY_P);
    assign w_press_esc   = (keycode == KEY_ESC)   && (r_key_prev != KEY_ESC);

    // Gating uses the pre-edge state, so a state change and a count update can share a frame.
    assign w_cnt_en  = jump_en && (r_state == PLAY);
    assign w_slow_en = w_fast_wrap && w_cnt_en;

    assign outstate = r_state;
    assign loadplat = r_loadplat;

    // State, reload pulse and previous-keycode registers.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= START;
            r_loadplat <= 1'b0;
            r_key_prev <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_loadplat <= w_loadplat_next;
            r_key_prev <= keycode;
        end
    end

    // Next-state and reload-pulse decode from key press events.
    always_comb begin
        w_next          = r_state;
        w_loadplat_next = 1'b0;
        case (r_state)
            START: begin
                if (w_press_enter) begin
                    w_next          = PLAY;
                    w_loadplat_next = 1'b1;
                end
            end
            PLAY: begin
                if (w_press_p) begin
                    w_next = PAUSE;
                end else if (w_press_esc) begin
                    w_next = START;
                end
            end
            PAUSE: begin
                if (w_press_p || w_press_enter) begin
                    w_next = PLAY;
                end else if (w_press_esc) begin
                    w_next = START;
                end
            end
            default: w_next = START;
        endcase
    end

    jump_timer #(.WIDTH(FAST_W)) u_fast (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clr       (jump_clr),
        .en        (w_cnt_en),
        .out       (jump_count),
        .wrap      (w_fast_wrap)
    );

    jump_timer #(.WIDTH(SLOW_W)) u_slow (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .clr       (jump_clr),
        .en        (w_slow_en),
        .out       (accel),
        .wrap      (w_slow_wrap_unused)
    );

endmodule

// File: tb/tb_jump_fsm_counter.sv
// Scoreboard bench: the driver applies one frame of stimulus per falling edge
// and queues the reference model's expected outputs; the monitor pops and
// compares after every rising edge.
module tb_jump_fsm_counter;

    localparam int FAST_W = 7;
    localparam int SLOW_W = 2;
    localparam int TOTAL_MOD = 1 << (FAST_W + SLOW_W);

    logic              frame_clk = 1'b0;
    logic              Reset = 1'b1;
    logic [7:0]        keycode = 8'h00;
    logic              jump_en = 1'b0;
    logic              jump_clr = 1'b0;
    logic [2:0]        outstate;
    logic              loadplat;
    logic [FAST_W-1:0] jump_count;
    logic [SLOW_W-1:0] accel;

    jump_fsm_counter #(.FAST_W(FAST_W), .SLOW_W(SLOW_W)) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .jump_en    (jump_en),
        .jump_clr   (jump_clr),
        .outstate   (outstate),
        .loadplat   (loadplat),
        .jump_count (jump_count),
        .accel      (accel)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int st;
        int lp;
        int jc;
        int ac;
        int frame;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int frame_no = 0;

    // Reference model: mode 0 start, 1 play, 2 pause, 3 invalid encoding.
    int m_mode = 0;
    int m_total = 0;
    logic [7:0] m_prev = 8'h00;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_total = 0;
        m_prev  = 8'h00;
    endtask

    // Drive inputs now and queue the expectation for the next rising edge.
    task automatic drive_frame(input logic [7:0] k, input bit en, input bit clr);
        exp_t e;
        bit p_enter, p_p, p_esc, cnt;
        int lp;
        keycode  = k;
        jump_en  = en;
        jump_clr = clr;
        p_enter = (k == 8'h28) && (m_prev != 8'h28);
        p_p     = (k == 8'h13) && (m_prev != 8'h13);
        p_esc   = (k == 8'h29) && (m_prev != 8'h29);
        cnt = en && (m_mode == 1);
        if (clr) m_total = 0;
        else if (cnt) m_total = (m_total + 1) % TOTAL_MOD;
        lp = 0;
        case (m_mode)
            0: if (p_enter) begin m_mode = 1; lp = 1; end
            1: if (p_p) m_mode = 2; else if (p_esc) m_mode = 0;
            2: if (p_p || p_enter) m_mode = 1; else if (p_esc) m_mode = 0;
            default: m_mode = 0;
        endcase
        m_prev = k;
        frame_no++;
        e.st = m_mode;
        e.lp = lp;
        e.jc = m_total % (1 << FAST_W);
        e.ac = m_total / (1 << FAST_W);
        e.frame = frame_no;
        q.push_back(e);
    endtask

    task automatic frame(input logic [7:0] k, input bit en, input bit clr);
        @(negedge frame_clk);
        drive_frame(k, en, clr);
    endtask

    task automatic frames(input int n, input logic [7:0] k, input bit en, input bit clr);
        for (int i = 0; i < n; i++) frame(k, en, clr);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " outstate"}, int'(outstate), 0);
        check({tag, " loadplat"}, int'(loadplat), 0);
        check({tag, " jump_count"}, int'(jump_count), 0);
        check({tag, " accel"}, int'(accel), 0);
    endtask

    // Monitor: one registered output set per frame.
    always @(posedge frame_clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("frame%0d outstate", e.frame), int'(outstate), e.st);
            check($sformatf("frame%0d loadplat", e.frame), int'(loadplat), e.lp);
            check($sformatf("frame%0d jump_count", e.frame), int'(jump_count), e.jc);
            check($sformatf("frame%0d accel", e.frame), int'(accel), e.ac);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] keys [5];
        logic [7:0] k;
        keys[0] = 8'h00; keys[1] = 8'h28; keys[2] = 8'h13; keys[3] = 8'h29; keys[4] = 8'h04;

        #2;
        check_zero("reset");
        @(negedge frame_clk);
        Reset = 1'b0;
        model_reset();

        frames(10, 8'h00, 1'b0, 1'b0);
        frames(5, 8'h28, 1'b0, 1'b0);
        frames(128, 8'h00, 1'b1, 1'b0);
        frames(384, 8'h00, 1'b1, 1'b0);
        frames(20, 8'h00, 1'b1, 1'b0);
        frame(8'h00, 1'b1, 1'b1);
        frames(7, 8'h00, 1'b1, 1'b0);
        frame(8'h13, 1'b1, 1'b0);
        frames(6, 8'h00, 1'b1, 1'b0);
        frame(8'h28, 1'b1, 1'b0);
        frames(3, 8'h00, 1'b1, 1'b0);
        frame(8'h29, 1'b1, 1'b0);
        frames(2, 8'h00, 1'b1, 1'b0);
        frame(8'h28, 1'b1, 1'b0);
        frames(130, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-count: outputs must clear before any edge.
        @(posedge frame_clk);
        #3;
        Reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge frame_clk);
        Reset = 1'b0;
        model_reset();
        frames(3, 8'h00, 1'b1, 1'b0);

        // Illegal encoding recovers to START; P in START is ignored.
        @(negedge frame_clk);
        force dut.r_state = 3'b101;
        #1;
        release dut.r_state;
        #1;
        check("forced outstate", int'(outstate), 5);
        m_mode = 3;
        drive_frame(8'h00, 1'b1, 1'b0);
        frame(8'h13, 1'b1, 1'b0);
        frames(2, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) k = keycode;
            else k = keys[$urandom_range(0, 4)];
            frame(k, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 2);
        end

        @(posedge frame_clk);
        #3;
        check("queue drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jump_fsm_counter.md
# jump_fsm_counter

Game-flow controller and jump-timing counter for the Doodle Jump character path. Decodes the keyboard keycode into a three-state game FSM (start / play / pause), pulses `loadplat` when a new game begins, and supplies a two-stage cascaded frame counter that the character motion logic uses as gravity acceleration. Clocked once per video frame.

## Interface
Parameters:
- `FAST_W`, default 7: width of the first-stage jump counter.
- `SLOW_W`, default 2: width of the second-stage acceleration counter.

Ports:
- `frame_clk`  in  1: frame clock; all state advances on its rising edge.
- `Reset`  in  1: global reset, asynchronous, active-high.
- `keycode`  in  8: current USB HID keycode; 0 = no key.
- `jump_en`  in  1: count enable from motion logic.
- `jump_clr`  in  1: synchronous clear of both counters.
- `outstate`  out  3: game state, 3'b000 START, 3'b001 PLAY, 3'b010 PAUSE.
- `loadplat`  out  1: one-frame pulse requesting platform reload.
- `jump_count`  out  FAST_W: first-stage count.
- `accel`  out  SLOW_W: second-stage count.

## Operation
- Key press event: `keycode == K` this frame and registered previous keycode `!= K`. Holding a key produces one event.
- Keycodes: ENTER 8'h28, P 8'h13, ESC 8'h29.
- START: ENTER press -> PLAY, with `loadplat` = 1 for that one frame. Other keys ignored.
- PLAY: P press -> PAUSE. ESC press -> START.
- PAUSE: P or ENTER press -> PLAY, with no `loadplat`. ESC press -> START.
- Unused encodings 3'b011–3'b111 -> START on the next edge.
- Counter enable is gated: `cnt_en = jump_en && outstate == PLAY`.
- `jump_clr` = 1 zeroes both counters and has priority over `cnt_en`.
- When `cnt_en` is set, `jump_count` increments modulo 2^FAST_W.
- `accel` increments modulo 2^SLOW_W only on the frame where `jump_count` wraps from all-ones to 0.
- When `cnt_en` is 0 and `jump_clr` is 0, both counters hold their values, including while in START or PAUSE.

## Timing
- All outputs are registered. A key event or control input sampled at edge N is reflected after edge N.
- Reset values: `outstate` = 3'b000, `loadplat` = 0, `jump_count` = 0, `accel` = 0, previous-keycode register = 8'h00.
- Reset applies immediately and asynchronously, including mid-count and mid-game.
- Key events in the same frame as `jump_clr` are independent; both take effect.
- An ESC or P press on the same frame as a counter wrap: state changes and the counter still updates that frame, since gating uses the pre-edge state.

## Structure
- Package `jump_pkg` contains:
  - state enum `game_state_t` with START = 3'b000, PLAY = 3'b001, PAUSE = 3'b010;
  - localparams `KEY_ENTER`, `KEY_P`, `KEY_ESC`.
- Sub-module `jump_timer`: parameterized `WIDTH` counter with async `Reset`, sync `clr`, `en`, output `out` and a `wrap` flag. Instantiated twice: FAST_W stage, and SLOW_W stage enabled by the first stage's `wrap` AND `cnt_en`.
- FSM and key edge detector live in the top.

## Test plan
- Reset, then no keys for 10 frames -> `outstate` = 000, `loadplat` = 0, counts = 0. Assert `Reset` mid-count -> all zero immediately, without waiting for a clock edge.
- ENTER held for 5 frames from START -> PLAY after the first edge; `loadplat` high exactly 1 frame; no retrigger while the key is held.
- In PLAY, `jump_en` = 1 for 128 frames -> `jump_count` wraps to 0 and `accel` = 1. Continue to 512 frames -> `accel` = 0 (wrapped).
- `jump_clr` and `jump_en` both 1 -> counts become 0. In PAUSE with `jump_en` = 1 -> counts hold.
- State sequence PLAY -P-> PAUSE -ENTER-> PLAY (no `loadplat`) -ESC-> START -ENTER-> PLAY (`loadplat` pulse).
- Force `outstate` register to 3'b101 -> START next edge. Press P while in START -> stays in START.
